// File: rtl/second_fill_strip_if.sv
// -----------------------------------------------------------------------------
// second_fill_strip_if
//   AXI-Stream style word channel shared by the padded input side and the
//   stripped output side of second_fill_strip.
//   Signals:
//     tdata  [DATA_W]  stream word
//     tvalid           word valid (driven by master)
//     tlast            last word of frame (driven by master)
//     tready           word accept (driven by slave)
//   Modports:
//     master  drives tdata/tvalid/tlast, samples tready
//     slave   samples tdata/tvalid/tlast, drives tready
// -----------------------------------------------------------------------------
interface second_fill_strip_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/second_fill_strip.sv
// -----------------------------------------------------------------------------
// second_fill_strip
//   Receives a padded frame of (IMG_H+2*PAD) x (IMG_W+2*PAD) words in
//   row-major order and forwards only the IMG_H x IMG_W interior words.
//   Border words are accepted and discarded. A single output register sits
//   on the master side (latency 1 from the accepted interior word).
//   Ports:
//     S_AXIS_ACLK     clock, rising edge
//     S_AXIS_ARESETN  asynchronous reset, active low
//     s_axis          padded input stream (slave modport)
//     m_axis          interior output stream (master modport)
//     Busy            frame in progress (FSM not idle)
//     Frame_Err       one-cycle pulse when input TLAST is not where expected
// -----------------------------------------------------------------------------
module second_fill_strip #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int PAD    = 1
) (
   input  logic                   S_AXIS_ACLK,
   input  logic                   S_AXIS_ARESETN,
   second_fill_strip_if.slave     s_axis,
   second_fill_strip_if.master    m_axis,
   output logic                   Busy,
   output logic                   Frame_Err
);

   localparam int PW       = IMG_W + 2*PAD;
   localparam int FILL_LEN = PAD*PW + PAD;   // leading/trailing border run
   localparam int GAP_LEN  = 2*PAD;          // right border + next left border
   localparam int CNT_W    = $clog2(FILL_LEN + 1);
   localparam int COL_W    = $clog2(IMG_W + 1);
   localparam int ROW_W    = $clog2(IMG_H + 1);

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

   typedef enum logic [2:0] {IDLE, HEAD, DATA, GAP, TAIL} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [COL_W-1:0]  col, col_nxt;
   logic [ROW_W-1:0]  row, row_nxt;

   logic              s_rdy;
   logic              beat;
   logic              load;
   logic              last_nxt;
   logic              err_nxt;
   logic              abort;

   logic [DATA_W-1:0] tdata_p1;
   logic              tlast_p1;
   logic              vld_p1;
   logic              err_p1;

   // Border words are always swallowed; interior words wait for a free
   // output slot.
   always_comb begin
      s_rdy = 1'b0;
      unique case (state)
         HEAD, GAP, TAIL: s_rdy = 1'b1;
         DATA:            s_rdy = !vld_p1 || m_axis.tready;
         default:         s_rdy = 1'b0;
      endcase
   end

   assign beat = s_axis.tvalid && s_rdy;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      col_nxt   = col;
      row_nxt   = row;
      load      = 1'b0;
      last_nxt  = 1'b0;
      err_nxt   = 1'b0;
      abort     = 1'b0;

      unique case (state)
         IDLE: begin
            // Leaving IDLE consumes no word: one bubble cycle per frame.
            if (s_axis.tvalid) state_nxt = HEAD;
         end
         HEAD: begin
            if (beat) begin
               if (s_axis.tlast)          abort = 1'b1;
               else if (cnt == FILL_LAST) begin
                  state_nxt = DATA;
                  cnt_nxt   = '0;
                  col_nxt   = '0;
                  row_nxt   = '0;
               end
               else                       cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (beat) begin
               // The word that carries a premature TLAST is not forwarded.
               if (s_axis.tlast) abort = 1'b1;
               else begin
                  load = 1'b1;
                  if (col == COL_LAST) begin
                     col_nxt = '0;
                     if (row == ROW_LAST) begin
                        state_nxt = TAIL;
                        last_nxt  = 1'b1;
                     end
                     else begin
                        state_nxt = GAP;
                        row_nxt   = row + 1'b1;
                     end
                  end
                  else col_nxt = col + 1'b1;
               end
            end
         end
         GAP: begin
            if (beat) begin
               if (s_axis.tlast)         abort = 1'b1;
               else if (cnt == GAP_LAST) begin
                  state_nxt = DATA;
                  cnt_nxt   = '0;
               end
               else                      cnt_nxt = cnt + 1'b1;
            end
         end
         TAIL: begin
            if (beat) begin
               if (cnt == FILL_LAST) begin
                  state_nxt = IDLE;
                  err_nxt   = !s_axis.tlast;
               end
               else if (s_axis.tlast) abort = 1'b1;
               else                   cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (abort) begin
         state_nxt = IDLE;
         err_nxt   = 1'b1;
      end

      if (state_nxt == IDLE) begin
         cnt_nxt = '0;
         col_nxt = '0;
         row_nxt = '0;
      end
   end

   // Control state
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state  <= IDLE;
         cnt    <= '0;
         col    <= '0;
         row    <= '0;
         err_p1 <= 1'b0;
      end
      else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         col    <= col_nxt;
         row    <= row_nxt;
         err_p1 <= err_nxt;
      end
   end

   // ---- stage p1: output register ----
   // Reset also zeroes the data word so the output bus reads 0 after reset.
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         tdata_p1 <= '0;
         tlast_p1 <= 1'b0;
         vld_p1   <= 1'b0;
      end
      else if (load) begin
         tdata_p1 <= s_axis.tdata;
         tlast_p1 <= last_nxt;
         vld_p1   <= 1'b1;
      end
      else if (m_axis.tready) begin
         tdata_p1 <= '0;
         tlast_p1 <= 1'b0;
         vld_p1   <= 1'b0;
      end
   end

   assign s_axis.tready = s_rdy;
   assign m_axis.tdata  = tdata_p1;
   assign m_axis.tlast  = tlast_p1;
   assign m_axis.tvalid = vld_p1;
   assign Busy          = (state != IDLE);
   assign Frame_Err     = err_p1;

endmodule

// File: tb/tb_second_fill_strip.sv
module tb_second_fill_strip;

   localparam int DATA_W = 16;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int PAD    = 1;
   localparam int PW     = IMG_W + 2*PAD;
   localparam int PH     = IMG_H + 2*PAD;
   localparam int FRAME  = PW * PH;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, frame_err;

   always #5 clk = ~clk;

   second_fill_strip_if #(.DATA_W(DATA_W)) s_if ();
   second_fill_strip_if #(.DATA_W(DATA_W)) m_if ();

   second_fill_strip #(
      .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .PAD(PAD)
   ) dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESETN (rst_n),
      .s_axis         (s_if.slave),
      .m_axis         (m_if.master),
      .Busy           (busy),
      .Frame_Err      (frame_err)
   );

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] frame_v [FRAME];
   logic [DATA_W:0]   got_q[$];
   logic [DATA_W:0]   exp_q[$];
   int                err_pulses = 0;
   int                err_wide   = 0;
   int                rdy_viol   = 0;
   logic              err_prev   = 1'b0;

   int m_mode   = 0;   // 0: always ready, 1: random, 2: stall window
   int cyc      = 0;
   int stall_lo = 0;
   int stall_hi = -1;

   // downstream ready generator
   always begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      case (m_mode)
         1:       m_if.tready = ($urandom_range(0, 1) == 1);
         2:       m_if.tready = !(cyc >= stall_lo && cyc <= stall_hi);
         default: m_if.tready = 1'b1;
      endcase
   end

   // observer: records completed output transfers and error pulses
   always @(negedge clk) begin
      if (m_if.tvalid && m_if.tready) got_q.push_back({m_if.tlast, m_if.tdata});
      if (frame_err) begin
         err_pulses <= err_pulses + 1;
         if (err_prev) err_wide <= err_wide + 1;
      end
      err_prev <= frame_err;
      if (busy && m_if.tready && !s_if.tready) rdy_viol <= rdy_viol + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Interior words are those whose padded (row,col) falls inside the
   // border; a TLAST seen before the final word ends the frame there and
   // that word itself is not forwarded.
   task automatic build_exp(input int tlast_pos);
      int lim, r, c;
      lim = (tlast_pos >= 0 && tlast_pos < FRAME-1) ? tlast_pos : FRAME;
      for (int i = 0; i < lim; i++) begin
         r = i / PW;
         c = i % PW;
         if (r >= PAD && r < PAD+IMG_H && c >= PAD && c < PAD+IMG_W)
            exp_q.push_back({(r == PAD+IMG_H-1 && c == PAD+IMG_W-1), frame_v[i]});
      end
   endtask

   task automatic fill_seq(input int base);
      for (int i = 0; i < FRAME; i++) frame_v[i] = DATA_W'(base + i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < FRAME; i++) frame_v[i] = DATA_W'($urandom);
   endtask

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      err_pulses = 0;
      err_wide   = 0;
      rdy_viol   = 0;
   endtask

   // ---------------- stimulus ----------------
   task automatic push_word(input logic [DATA_W-1:0] d, input logic l,
                            output int cycles, output bit ok);
      logic acc;
      cycles = 0;
      acc    = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = l;
      while (!acc && cycles < 200) begin
         @(negedge clk);
         acc = s_if.tready;
         @(posedge clk);
         #1;
         cycles++;
      end
      ok = acc;
   endtask

   task automatic send_frame(input int tlast_pos, input int n_words,
                             input bit keep_valid, output int cycles);
      int c;
      bit ok;
      cycles = 0;
      for (int i = 0; i < n_words; i++) begin
         push_word(frame_v[i], (i == tlast_pos), c, ok);
         cycles += c;
         if (!ok) begin
            total++;
            bad++;
            $display("FAIL input_accept_timeout word=%0d got=stalled exp=accepted", i);
            break;
         end
      end
      if (!keep_valid) begin
         s_if.tvalid = 1'b0;
         s_if.tlast  = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!m_if.tvalid && got_q.size() >= exp_q.size()) break;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      s_if.tvalid = 1'b1;
      s_if.tdata  = 16'hBEEF;
      s_if.tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b exp=0", m_if.tvalid); end
      total++; if (m_if.tdata !== '0) begin bad++; $display("FAIL reset_m_tdata got=%h exp=0", m_if.tdata); end
      total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL reset_m_tlast got=%b exp=0", m_if.tlast); end
      total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_if.tready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      s_if.tvalid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_clean_frame();
      int cycles;
      clear_obs();
      m_mode = 0;
      fill_seq(0);
      build_exp(FRAME-1);
      send_frame(FRAME-1, FRAME, 1'b0, cycles);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clean_busy_after got=%b exp=0", busy); end
      total++; if (cycles != FRAME+1) begin bad++; $display("FAIL clean_cycles got=%0d exp=%0d", cycles, FRAME+1); end
      wait_drain();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL clean_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL clean_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (err_pulses != 0) begin bad++; $display("FAIL clean_frame_err got=%0d exp=0", err_pulses); end
   endtask

   task automatic test_backpressure();
      int cycles;
      clear_obs();
      fill_seq(0);
      build_exp(FRAME-1);
      stall_lo = cyc + 12;
      stall_hi = cyc + 16;
      m_mode   = 2;
      send_frame(FRAME-1, FRAME, 1'b0, cycles);
      wait_drain();
      m_mode = 0;
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (rdy_viol != 0) begin bad++; $display("FAIL bp_s_tready_low_while_m_ready got=%0d exp=0", rdy_viol); end
      total++; if (cycles <= FRAME+1) begin bad++; $display("FAIL bp_stall_effect got=%0d exp=>%0d", cycles, FRAME+1); end
      total++; if (err_pulses != 0) begin bad++; $display("FAIL bp_frame_err got=%0d exp=0", err_pulses); end
   endtask

   task automatic test_early_tlast();
      int cycles;
      clear_obs();
      m_mode = 0;
      fill_seq(0);
      build_exp(15);
      send_frame(15, 16, 1'b0, cycles);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL early_busy got=%b exp=0", busy); end
      wait_drain();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL early_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL early_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (err_pulses != 1) begin bad++; $display("FAIL early_err_pulses got=%0d exp=1", err_pulses); end
      total++; if (err_wide != 0) begin bad++; $display("FAIL early_err_width got=%0d exp=0", err_wide); end
      // recovery frame
      clear_obs();
      fill_seq(100);
      build_exp(FRAME-1);
      send_frame(FRAME-1, FRAME, 1'b0, cycles);
      wait_drain();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL early_next_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL early_next_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (err_pulses != 0) begin bad++; $display("FAIL early_next_err got=%0d exp=0", err_pulses); end
   endtask

   task automatic test_missing_tlast();
      int cycles;
      clear_obs();
      m_mode = 0;
      fill_seq(0);
      build_exp(-1);
      send_frame(-1, FRAME, 1'b0, cycles);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL miss_busy got=%b exp=0", busy); end
      wait_drain();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL miss_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL miss_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (err_pulses != 1) begin bad++; $display("FAIL miss_err_pulses got=%0d exp=1", err_pulses); end
      clear_obs();
      fill_rand();
      build_exp(FRAME-1);
      send_frame(FRAME-1, FRAME, 1'b0, cycles);
      wait_drain();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL miss_next_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL miss_next_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (err_pulses != 0) begin bad++; $display("FAIL miss_next_err got=%0d exp=0", err_pulses); end
   endtask

   task automatic test_back_to_back();
      int c1, c2, lasts;
      clear_obs();
      m_mode = 0;
      fill_seq(200);
      build_exp(FRAME-1);
      send_frame(FRAME-1, FRAME, 1'b1, c1);
      fill_seq(300);
      build_exp(FRAME-1);
      send_frame(FRAME-1, FRAME, 1'b0, c2);
      wait_drain();
      total++; if (c2 != FRAME+1) begin bad++; $display("FAIL b2b_bubble_cycles got=%0d exp=%0d", c2, FRAME+1); end
      total++; if (got_q.size() != 2*IMG_W*IMG_H) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2*IMG_W*IMG_H); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      lasts = 0;
      foreach (got_q[i]) if (got_q[i][DATA_W]) lasts++;
      total++; if (lasts != 2) begin bad++; $display("FAIL b2b_tlast_count got=%0d exp=2", lasts); end
      total++; if (err_pulses != 0) begin bad++; $display("FAIL b2b_frame_err got=%0d exp=0", err_pulses); end
   endtask

   task automatic test_reset_mid_frame();
      int cycles;
      clear_obs();
      m_mode = 0;
      fill_seq(0);
      build_exp(14);
      send_frame(-1, 15, 1'b1, cycles);
      rst_n = 1'b0;
      #1;
      total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL midrst_m_tvalid got=%b exp=0", m_if.tvalid); end
      total++; if (m_if.tdata !== '0) begin bad++; $display("FAIL midrst_m_tdata got=%h exp=0", m_if.tdata); end
      total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL midrst_s_tready got=%b exp=0", s_if.tready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      s_if.tvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      clear_obs();
      fill_rand();
      build_exp(FRAME-1);
      send_frame(FRAME-1, FRAME, 1'b0, cycles);
      wait_drain();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_next_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_next_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      total++; if (err_pulses != 0) begin bad++; $display("FAIL midrst_next_err got=%0d exp=0", err_pulses); end
   endtask

   task automatic test_random();
      int cycles, pos, sel, n, exp_err;
      for (int f = 0; f < 8; f++) begin
         clear_obs();
         m_mode = 1;
         fill_rand();
         sel = $urandom_range(0, 3);
         if (sel == 0)      pos = $urandom_range(0, FRAME-2);
         else if (sel == 1) pos = -1;
         else               pos = FRAME-1;
         n       = (pos >= 0) ? pos + 1 : FRAME;
         exp_err = (pos == FRAME-1) ? 0 : 1;
         build_exp(pos);
         send_frame(pos, n, 1'b0, cycles);
         wait_drain();
         total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count pos=%0d got=%0d exp=%0d", f, pos, got_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_word[%0d] got=%h exp=%h", f, i, got_q[i], exp_q[i]); end
         end
         total++; if (err_pulses != exp_err) begin bad++; $display("FAIL rand%0d_err pos=%0d got=%0d exp=%0d", f, pos, err_pulses, exp_err); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand%0d_busy got=%b exp=0", f, busy); end
      end
      m_mode = 0;
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      test_reset();
      test_clean_frame();
      test_backpressure();
      test_early_tlast();
      test_missing_tlast();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
